axi4_lite_arbiter: RTL and testbench

Round-robin N:1 AXI4-Lite interconnect that lets several AXI4-Lite managers share one AXI4-Lite subordinate, such as the register-file slave. Read and write channels are arbitrated independently, so one read and one write can be in flight at the same time. Each channel allows one outstanding transaction. Addresses, data, strobes and responses pass through unmodified; there is no address decode.

---
 rtl/axi4_lite_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_axi4_lite_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_arbiter.sv
// Round-robin N:1 AXI4-Lite arbiter. Read and write channels are arbitrated independently,
// each with one outstanding transaction. Payloads pass through and are zero while no transaction owns them.
module axi4_lite_arbiter #(
    parameter int NUM_MASTERS  = 2,
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_clk_i,
    // upstream managers
    input  logic [NUM_MASTERS*ADDRESS_SIZE-1:0] s_awaddr_i,
    input  logic [NUM_MASTERS-1:0]              s_awvalid_i,
    output logic [NUM_MASTERS-1:0]              s_awready_o,
    input  logic [NUM_MASTERS*DATA_SIZE-1:0]    s_wdata_i,
    input  logic [NUM_MASTERS*DATA_SIZE/8-1:0]  s_wstrb_i,
    input  logic [NUM_MASTERS-1:0]              s_wvalid_i,
    output logic [NUM_MASTERS-1:0]              s_wready_o,
    output logic [NUM_MASTERS*2-1:0]            s_bresp_o,
    output logic [NUM_MASTERS-1:0]              s_bvalid_o,
    input  logic [NUM_MASTERS-1:0]              s_bready_i,
    input  logic [NUM_MASTERS*ADDRESS_SIZE-1:0] s_araddr_i,
    input  logic [NUM_MASTERS-1:0]              s_arvalid_i,
    output logic [NUM_MASTERS-1:0]              s_arready_o,
    output logic [NUM_MASTERS*DATA_SIZE-1:0]    s_rdata_o,
    output logic [NUM_MASTERS*2-1:0]            s_rresp_o,
    output logic [NUM_MASTERS-1:0]              s_rvalid_o,
    input  logic [NUM_MASTERS-1:0]              s_rready_i,
    // downstream subordinate
    output logic [ADDRESS_SIZE-1:0]             m_awaddr_o,
    output logic                                m_awvalid_o,
    input  logic                                m_awready_i,
    output logic [DATA_SIZE-1:0]                m_wdata_o,
    output logic [DATA_SIZE/8-1:0]              m_wstrb_o,
    output logic                                m_wvalid_o,
    input  logic                                m_wready_i,
    input  logic [1:0]                          m_bresp_i,
    input  logic                                m_bvalid_i,
    output logic                                m_bready_o,
    output logic [ADDRESS_SIZE-1:0]             m_araddr_o,
    output logic                                m_arvalid_o,
    input  logic                                m_arready_i,
    input  logic [DATA_SIZE-1:0]                m_rdata_i,
    input  logic [1:0]                          m_rresp_i,
    input  logic                                m_rvalid_i,
    output logic                                m_rready_o
);

    localparam int IDX_W  = $clog2(NUM_MASTERS);
    localparam int STRB_W = DATA_SIZE / 8;

    typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

    w_state_e         w_state;
    r_state_e         r_state;
    logic [IDX_W-1:0] w_grant, w_ptr, r_grant, r_ptr;
    logic             aw_done, w_done;
    logic             aw_active, w_active, aw_hs, w_hs, b_hs, ar_hs, r_hs;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_MASTERS - 1) ? '0 : idx + 1'b1;
    endfunction

    // First requester at or after the pointer, wrapping past the top index.
    function automatic logic [IDX_W-1:0] pick(input logic [NUM_MASTERS-1:0] req,
                                              input logic [IDX_W-1:0]       ptr);
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] win;
        logic             found;
        idx   = ptr;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
            idx = next_idx(idx);
        end
        return win;
    endfunction

    assign aw_active = (w_state == W_XFER) && !aw_done;
    assign w_active  = (w_state == W_XFER) && !w_done;
    assign aw_hs     = m_awvalid_o && m_awready_i;
    assign w_hs      = m_wvalid_o && m_wready_i;
    assign b_hs      = (w_state == W_RESP) && m_bvalid_i && m_bready_o;
    assign ar_hs     = m_arvalid_o && m_arready_i;
    assign r_hs      = (r_state == R_DATA) && m_rvalid_i && m_rready_o;

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        m_awaddr_o  = '0;
        m_awvalid_o = 1'b0;
        m_wdata_o   = '0;
        m_wstrb_o   = '0;
        m_wvalid_o  = 1'b0;
        m_bready_o  = 1'b0;
        s_awready_o = '0;
        s_wready_o  = '0;
        s_bvalid_o  = '0;
        s_bresp_o   = '0;
        m_araddr_o  = '0;
        m_arvalid_o = 1'b0;
        m_rready_o  = 1'b0;
        s_arready_o = '0;
        s_rvalid_o  = '0;
        s_rdata_o   = '0;
        s_rresp_o   = '0;

        if (aw_active) begin
            m_awaddr_o           = s_awaddr_i[int'(w_grant)*ADDRESS_SIZE +: ADDRESS_SIZE];
            m_awvalid_o          = s_awvalid_i[w_grant];
            s_awready_o[w_grant] = m_awready_i;
        end
        if (w_active) begin
            m_wdata_o           = s_wdata_i[int'(w_grant)*DATA_SIZE +: DATA_SIZE];
            m_wstrb_o           = s_wstrb_i[int'(w_grant)*STRB_W +: STRB_W];
            m_wvalid_o          = s_wvalid_i[w_grant];
            s_wready_o[w_grant] = m_wready_i;
        end
        if (w_state == W_RESP) begin
            s_bvalid_o[w_grant] = m_bvalid_i;
            s_bresp_o           = {NUM_MASTERS{m_bresp_i}};
            m_bready_o          = s_bready_i[w_grant];
        end
        if (r_state == R_ADDR) begin
            m_araddr_o           = s_araddr_i[int'(r_grant)*ADDRESS_SIZE +: ADDRESS_SIZE];
            m_arvalid_o          = s_arvalid_i[r_grant];
            s_arready_o[r_grant] = m_arready_i;
        end
        if (r_state == R_DATA) begin
            s_rvalid_o[r_grant] = m_rvalid_i;
            s_rdata_o           = {NUM_MASTERS{m_rdata_i}};
            s_rresp_o           = {NUM_MASTERS{m_rresp_i}};
            m_rready_o          = s_rready_i[r_grant];
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state uses non-blocking assignments so every register updates together at the edge.
        if (rst_clk_i) begin
            w_state <= W_IDLE;
            w_grant <= '0;
            w_ptr   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            r_state <= R_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            case (w_state)
                W_IDLE: if (|s_awvalid_i) begin
                    w_grant <= pick(s_awvalid_i, w_ptr);
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    w_state <= W_XFER;
                end
                W_XFER: begin
                    aw_done <= aw_done | aw_hs;
                    w_done  <= w_done | w_hs;
                    if ((aw_done | aw_hs) && (w_done | w_hs)) w_state <= W_RESP;
                end
                W_RESP: if (b_hs) begin
                    w_ptr   <= next_idx(w_grant);
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase

            case (r_state)
                R_IDLE: if (|s_arvalid_i) begin
                    r_grant <= pick(s_arvalid_i, r_ptr);
                    r_state <= R_ADDR;
                end
                R_ADDR: if (ar_hs) r_state <= R_DATA;
                R_DATA: if (r_hs) begin
                    r_ptr   <= next_idx(r_grant);
                    r_state <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed bench for axi4_lite_arbiter with two managers; the bench drives the subordinate side by hand.
module tb_axi4_lite_arbiter;

    localparam int N = 2;
    localparam int A = 32;
    localparam int D = 32;

    logic           clk_i = 1'b0;
    logic           rst_clk_i;
    logic [N*A-1:0] s_awaddr_i, s_araddr_i;
    logic [N-1:0]   s_awvalid_i, s_awready_o, s_wvalid_i, s_wready_o, s_bvalid_o, s_bready_i;
    logic [N-1:0]   s_arvalid_i, s_arready_o, s_rvalid_o, s_rready_i;
    logic [N*D-1:0] s_wdata_i, s_rdata_o;
    logic [N*D/8-1:0] s_wstrb_i;
    logic [N*2-1:0] s_bresp_o, s_rresp_o;
    logic [A-1:0]   m_awaddr_o, m_araddr_o;
    logic [D-1:0]   m_wdata_o, m_rdata_i;
    logic [D/8-1:0] m_wstrb_o;
    logic           m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i, m_bvalid_i, m_bready_o;
    logic           m_arvalid_o, m_arready_i, m_rvalid_i, m_rready_o;
    logic [1:0]     m_bresp_i, m_rresp_i;

    int checks = 0;
    int errors = 0;

    axi4_lite_arbiter #(.NUM_MASTERS(N), .ADDRESS_SIZE(A), .DATA_SIZE(D)) dut (
        .clk_i(clk_i), .rst_clk_i(rst_clk_i),
        .s_awaddr_i(s_awaddr_i), .s_awvalid_i(s_awvalid_i), .s_awready_o(s_awready_o),
        .s_wdata_i(s_wdata_i), .s_wstrb_i(s_wstrb_i), .s_wvalid_i(s_wvalid_i), .s_wready_o(s_wready_o),
        .s_bresp_o(s_bresp_o), .s_bvalid_o(s_bvalid_o), .s_bready_i(s_bready_i),
        .s_araddr_i(s_araddr_i), .s_arvalid_i(s_arvalid_i), .s_arready_o(s_arready_o),
        .s_rdata_o(s_rdata_o), .s_rresp_o(s_rresp_o), .s_rvalid_o(s_rvalid_o), .s_rready_i(s_rready_i),
        .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
        .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
        .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
        .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        s_awaddr_i = '0; s_awvalid_i = '0; s_wdata_i = '0; s_wstrb_i = '0; s_wvalid_i = '0;
        s_bready_i = '0; s_araddr_i = '0; s_arvalid_i = '0; s_rready_i = '0;
        m_awready_i = 1'b0; m_wready_i = 1'b0; m_bresp_i = '0; m_bvalid_i = 1'b0;
        m_arready_i = 1'b0; m_rdata_i = '0; m_rresp_i = '0; m_rvalid_i = 1'b0;
    endtask

    task automatic set_write(input int i, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic aw, input logic w);
        s_awaddr_i[i*A +: A] = addr;
        s_wdata_i[i*D +: D]  = data;
        s_wstrb_i[i*4 +: 4]  = strb;
        s_awvalid_i[i]       = aw;
        s_wvalid_i[i]        = w;
    endtask

    // One full write with AW and W presented together; the winner drops its valids after the handshake.
    task automatic write_round(input int exp, input logic [31:0] ea, input logic [31:0] ed,
                               input logic [3:0] es, input logic [1:0] eb, input string tag);
        logic [N-1:0] oh;
        oh = N'(1) << exp;
        settle();
        check({tag, ".idle_awvalid"}, 64'(m_awvalid_o), 64'd0);
        tick(); settle();
        check({tag, ".awready"}, 64'(s_awready_o), 64'(oh));
        check({tag, ".wready"}, 64'(s_wready_o), 64'(oh));
        check({tag, ".awvalid"}, 64'(m_awvalid_o), 64'd1);
        check({tag, ".awaddr"}, 64'(m_awaddr_o), 64'(ea));
        check({tag, ".wdata"}, 64'(m_wdata_o), 64'(ed));
        check({tag, ".wstrb"}, 64'(m_wstrb_o), 64'(es));
        tick();
        s_awvalid_i[exp] = 1'b0;
        s_wvalid_i[exp]  = 1'b0;
        m_bvalid_i = 1'b1;
        m_bresp_i  = eb;
        s_bready_i = '1;
        settle();
        check({tag, ".bvalid"}, 64'(s_bvalid_o), 64'(oh));
        check({tag, ".bresp"}, 64'(s_bresp_o[exp*2 +: 2]), 64'(eb));
        check({tag, ".bready"}, 64'(m_bready_o), 64'd1);
        check({tag, ".resp_awvalid"}, 64'(m_awvalid_o), 64'd0);
        tick();
        m_bvalid_i = 1'b0;
        m_bresp_i  = '0;
        settle();
        check({tag, ".bvalid_done"}, 64'(s_bvalid_o), 64'd0);
    endtask

    initial begin
        clear_inputs();
        rst_clk_i = 1'b1;
        tick(); tick(); settle();
        check("rst.awvalid", 64'(m_awvalid_o), 64'd0);
        check("rst.arvalid", 64'(m_arvalid_o), 64'd0);
        check("rst.s_ready", 64'({s_awready_o, s_wready_o, s_arready_o}), 64'd0);
        check("rst.s_valid", 64'({s_bvalid_o, s_rvalid_o}), 64'd0);
        check("rst.m_ready", 64'({m_bready_o, m_rready_o}), 64'd0);
        check("rst.payload", 64'({m_awaddr_o, m_wdata_o}), 64'd0);
        rst_clk_i = 1'b0;

        // Single M0 write, AW and W together.
        tick();
        set_write(0, 32'h0, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1);
        m_awready_i = 1'b1; m_wready_i = 1'b1;
        write_round(0, 32'h0, 32'hDEAD_BEEF, 4'hF, 2'b00, "s1");

        // Both managers contend repeatedly: grants alternate starting from M0.
        rst_clk_i = 1'b1; clear_inputs(); tick(); rst_clk_i = 1'b0;
        m_awready_i = 1'b1; m_wready_i = 1'b1;
        set_write(0, 32'h100, 32'h1000_0001, 4'h3, 1'b1, 1'b1);
        set_write(1, 32'h104, 32'h2000_0001, 4'hC, 1'b1, 1'b1);
        write_round(0, 32'h100, 32'h1000_0001, 4'h3, 2'b00, "s2.r0");
        set_write(0, 32'h108, 32'h1000_0002, 4'h1, 1'b1, 1'b1);
        write_round(1, 32'h104, 32'h2000_0001, 4'hC, 2'b10, "s2.r1");
        set_write(1, 32'h10C, 32'h2000_0002, 4'h8, 1'b1, 1'b1);
        write_round(0, 32'h108, 32'h1000_0002, 4'h1, 2'b00, "s2.r2");
        write_round(1, 32'h10C, 32'h2000_0002, 4'h8, 2'b00, "s2.r3");

        // M1 AW well ahead of W; AW must be issued exactly once.
        tick();
        set_write(1, 32'h10, 32'h0, 4'hF, 1'b1, 1'b0);
        tick(); settle();
        check("s3.awvalid", 64'(m_awvalid_o), 64'd1);
        check("s3.wvalid_early", 64'(m_wvalid_o), 64'd0);
        check("s3.awready", 64'(s_awready_o), 64'b10);
        tick(); settle();
        check("s3.aw_masked", 64'(m_awvalid_o), 64'd0);
        check("s3.awready_masked", 64'(s_awready_o), 64'd0);
        tick();
        s_awvalid_i[1] = 1'b0;
        settle();
        check("s3.wvalid_wait", 64'(m_wvalid_o), 64'd0);
        tick();
        set_write(1, 32'h10, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1);
        settle();
        check("s3.wvalid", 64'(m_wvalid_o), 64'd1);
        check("s3.wdata", 64'(m_wdata_o), 64'hCAFE_F00D);
        check("s3.no_second_aw", 64'(m_awvalid_o), 64'd0);
        tick();
        s_wvalid_i[1] = 1'b0;
        m_bvalid_i = 1'b1; s_bready_i = '1;
        settle();
        check("s3.bvalid", 64'(s_bvalid_o), 64'b10);
        tick();
        m_bvalid_i = 1'b0;

        // M0 write and M1 read in parallel.
        set_write(0, 32'h8, 32'h1234_5678, 4'hF, 1'b1, 1'b1);
        s_arvalid_i[1] = 1'b1; s_araddr_i[A +: A] = 32'h0; m_arready_i = 1'b1;
        tick(); settle();
        check("s4.awready", 64'(s_awready_o), 64'b01);
        check("s4.arready", 64'(s_arready_o), 64'b10);
        check("s4.both_valid", 64'({m_awvalid_o, m_arvalid_o}), 64'b11);
        tick();
        s_awvalid_i = '0; s_wvalid_i = '0; s_arvalid_i = '0;
        m_bvalid_i = 1'b1; m_rvalid_i = 1'b1; m_rdata_i = 32'hA5A5_0001; m_rresp_i = 2'b00;
        s_bready_i = '1; s_rready_i = '1;
        settle();
        check("s4.rvalid", 64'(s_rvalid_o), 64'b10);
        check("s4.rdata", 64'(s_rdata_o[D +: D]), 64'hA5A5_0001);
        check("s4.bvalid", 64'(s_bvalid_o), 64'b01);
        check("s4.m_readies", 64'({m_rready_o, m_bready_o}), 64'b11);
        tick();
        m_bvalid_i = 1'b0; m_rvalid_i = 1'b0;
        settle();
        check("s4.done", 64'({s_rvalid_o, s_bvalid_o}), 64'd0);

        // M0 stalls R for 5 cycles while M1 waits with a read request.
        s_arvalid_i[0] = 1'b1; s_araddr_i[0 +: A] = 32'h4;
        tick(); settle();
        check("s5.arready0", 64'(s_arready_o), 64'b01);
        check("s5.araddr0", 64'(m_araddr_o), 64'h4);
        tick();
        s_arvalid_i[0] = 1'b0;
        s_arvalid_i[1] = 1'b1; s_araddr_i[A +: A] = 32'h44;
        m_rvalid_i = 1'b1; m_rdata_i = 32'h0BAD_CAFE; s_rready_i = 2'b10;
        for (int c = 0; c < 5; c++) begin
            settle();
            check($sformatf("s5.stall%0d.rvalid", c), 64'(s_rvalid_o), 64'b01);
            check($sformatf("s5.stall%0d.rready", c), 64'(m_rready_o), 64'd0);
            check($sformatf("s5.stall%0d.ar", c), 64'({s_arready_o, m_arvalid_o}), 64'd0);
            tick();
        end
        s_rready_i = 2'b11;
        settle();
        check("s5.rready", 64'(m_rready_o), 64'd1);
        check("s5.rdata0", 64'(s_rdata_o[0 +: D]), 64'h0BAD_CAFE);
        tick();
        m_rvalid_i = 1'b0;
        settle();
        check("s5.idle_arready", 64'(s_arready_o), 64'd0);
        tick(); settle();
        check("s5.arready1", 64'(s_arready_o), 64'b10);
        check("s5.araddr1", 64'(m_araddr_o), 64'h44);
        tick();
        s_arvalid_i[1] = 1'b0; m_rvalid_i = 1'b1;
        settle();
        check("s5.rvalid1", 64'(s_rvalid_o), 64'b10);
        tick();
        m_rvalid_i = 1'b0;

        // Reset in W_XFER after AW only; state and pointer must not survive.
        set_write(1, 32'h20, 32'h0, 4'hF, 1'b1, 1'b0);
        tick(); settle();
        check("s6.awready", 64'(s_awready_o), 64'b10);
        tick();
        s_awvalid_i[1] = 1'b0;
        set_write(1, 32'h20, 32'h77, 4'hF, 1'b0, 1'b1);
        settle();
        check("s6.pre_rst_wvalid", 64'(m_wvalid_o), 64'd1);
        rst_clk_i = 1'b1;
        tick(); settle();
        check("s6.rst_wvalid", 64'(m_wvalid_o), 64'd0);
        check("s6.rst_readies", 64'({s_awready_o, s_wready_o, s_arready_o}), 64'd0);
        check("s6.rst_valids", 64'({m_awvalid_o, m_arvalid_o, s_bvalid_o, s_rvalid_o}), 64'd0);
        check("s6.rst_wdata", 64'(m_wdata_o), 64'd0);
        rst_clk_i = 1'b0;
        s_wvalid_i = '0;
        set_write(0, 32'h30, 32'h3030_3030, 4'hF, 1'b1, 1'b1);
        set_write(1, 32'h34, 32'h3434_3434, 4'h5, 1'b1, 1'b1);
        write_round(0, 32'h30, 32'h3030_3030, 4'hF, 2'b00, "s6.r0");
        write_round(1, 32'h34, 32'h3434_3434, 4'h5, 2'b00, "s6.r1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
